hazard_tracker: RTL and testbench

//  Parametrised RAW-hazard / forwarding / control-squash unit for the in-order pipeline.

---
 rtl/hazard_tracker.sv | 134 +++++++++++++
 tb/tb_hazard_tracker.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_tracker.sv
// hazard_tracker: RAW-hazard detection, per-operand forwarding select and
// control-squash bubble injection for the in-order pipeline.
module hazard_tracker #(
  parameter int               REG_AW       = 3,
  parameter int               DEPTH        = 4,
  parameter logic [DEPTH-1:0] FWD_MASK     = 4'b0011,
  parameter int               LOAD_FWD_MIN = 1,
  parameter int               SQUASH_CYC   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [REG_AW-1:0] in_rs,
  input  logic              in_rs_used,
  input  logic [REG_AW-1:0] in_rt,
  input  logic              in_rt_used,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_wr,
  input  logic              in_load,
  input  logic              in_ctl,
  input  logic              flush,
  output logic              stall,
  output logic              nop,
  output logic [DEPTH-1:0]  fwd_rs,
  output logic [DEPTH-1:0]  fwd_rt,
  output logic              squash_busy
);

  localparam int               CNT_W     = (SQUASH_CYC > 0) ? $clog2(SQUASH_CYC + 1) : 1;
  localparam logic             SQUASH_EN = (SQUASH_CYC > 0);
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(SQUASH_CYC);

  logic [DEPTH-1:0]             valid_q, valid_d;
  logic [DEPTH-1:0][REG_AW-1:0] rd_q, rd_d;
  logic [DEPTH-1:0]             load_q, load_d;
  logic [CNT_W-1:0]             count_q, count_d;

  logic [DEPTH-1:0] fwdOk;
  logic [DEPTH:0]   resRs, resRt;
  logic [DEPTH-1:0] fwdRs, fwdRt;
  logic             hazRs, hazRt;
  logic             squashBusy, hz, nopInt, issue;

  // Result of the youngest matching writer: {hazard, one-hot forward select}.
  function automatic logic [DEPTH:0] resolve(
    input logic [REG_AW-1:0]             src,
    input logic                          used,
    input logic [DEPTH-1:0]              valid,
    input logic [DEPTH-1:0][REG_AW-1:0]  rd,
    input logic [DEPTH-1:0]              okMask
  );
    logic [DEPTH-1:0] hit;
    logic [DEPTH-1:0] youngest;
    logic [DEPTH:0]   res;
    for (int k = 0; k < DEPTH; k++) begin
      hit[k] = valid[k] & (rd[k] == src);
    end
    youngest = hit & (~hit + DEPTH'(1));
    if (!used || (youngest == '0)) begin
      res = '0;
    end else if ((youngest & okMask) != '0) begin
      res = {1'b0, youngest};
    end else begin
      res = {1'b1, {DEPTH{1'b0}}};
    end
    return res;
  endfunction

  always_comb begin
    fwdOk = '0;
    for (int k = 0; k < DEPTH; k++) begin
      fwdOk[k] = FWD_MASK[k] & (~load_q[k] | (k >= LOAD_FWD_MIN));
    end
  end

  always_comb begin
    resRs = resolve(in_rs, in_rs_used, valid_q, rd_q, fwdOk);
    resRt = resolve(in_rt, in_rt_used, valid_q, rd_q, fwdOk);
    hazRs = resRs[DEPTH];
    hazRt = resRt[DEPTH];
    fwdRs = resRs[DEPTH-1:0];
    fwdRt = resRt[DEPTH-1:0];
  end

  // Wrong-path fetches under squash or flush must never stall the front end.
  assign squashBusy = (count_q != '0);
  assign hz         = in_valid & ~squashBusy & ~flush & (hazRs | hazRt);
  assign nopInt     = hz | squashBusy | flush;
  assign issue      = in_valid & ~nopInt;

  assign stall       = ~rst & hz;
  assign nop         = ~rst & nopInt;
  assign squash_busy = ~rst & squashBusy;
  assign fwd_rs      = (rst | nopInt) ? '0 : fwdRs;
  assign fwd_rt      = (rst | nopInt) ? '0 : fwdRt;

  always_comb begin
    valid_d    = valid_q;
    rd_d       = rd_q;
    load_d     = load_q;
    valid_d[0] = issue & in_wr;
    rd_d[0]    = in_rd;
    load_d[0]  = in_load;
    for (int k = 1; k < DEPTH; k++) begin
      valid_d[k] = valid_q[k-1];
      rd_d[k]    = rd_q[k-1];
      load_d[k]  = load_q[k-1];
    end
  end

  always_comb begin
    count_d = count_q;
    if (issue & in_ctl & SQUASH_EN) begin
      count_d = CNT_LOAD;
    end else if (count_q != '0) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid_q <= '0;
      rd_q    <= '0;
      load_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      rd_q    <= rd_d;
      load_q  <= load_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_hazard_tracker.sv
// Self-checking bench for hazard_tracker: directed scenarios with fixed
// expectations plus randomized traffic checked against a behavioural model.
module tb_hazard_tracker;

  localparam int               REG_AW       = 3;
  localparam int               DEPTH        = 4;
  localparam logic [DEPTH-1:0] FWD_MASK     = 4'b0011;
  localparam int               LOAD_FWD_MIN = 1;
  localparam int               SQUASH_CYC   = 2;
  localparam int               OW           = 3 + 2 * DEPTH;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic [REG_AW-1:0] in_rs;
  logic              in_rs_used;
  logic [REG_AW-1:0] in_rt;
  logic              in_rt_used;
  logic [REG_AW-1:0] in_rd;
  logic              in_wr;
  logic              in_load;
  logic              in_ctl;
  logic              flush;
  logic              stall;
  logic              nop;
  logic [DEPTH-1:0]  fwd_rs;
  logic [DEPTH-1:0]  fwd_rt;
  logic              squash_busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit v;
    int rd;
    bit ld;
  } ent_t;

  ent_t mq[DEPTH];
  int   mCount = 0;

  hazard_tracker #(
    .REG_AW      (REG_AW),
    .DEPTH       (DEPTH),
    .FWD_MASK    (FWD_MASK),
    .LOAD_FWD_MIN(LOAD_FWD_MIN),
    .SQUASH_CYC  (SQUASH_CYC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_rs      (in_rs),
    .in_rs_used (in_rs_used),
    .in_rt      (in_rt),
    .in_rt_used (in_rt_used),
    .in_rd      (in_rd),
    .in_wr      (in_wr),
    .in_load    (in_load),
    .in_ctl     (in_ctl),
    .flush      (flush),
    .stall      (stall),
    .nop        (nop),
    .fwd_rs     (fwd_rs),
    .fwd_rt     (fwd_rt),
    .squash_busy(squash_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  function automatic logic [OW-1:0] outs();
    return {stall, nop, squash_busy, fwd_rs, fwd_rt};
  endfunction

  function automatic logic [OW-1:0] pk(input logic s, input logic n, input logic b,
                                       input logic [DEPTH-1:0] frs,
                                       input logic [DEPTH-1:0] frt);
    return {s, n, b, frs, frt};
  endfunction

  // Scan from the youngest in-flight writer; the first register match decides.
  function automatic void lookupModel(input int src, input bit used,
                                      output logic [DEPTH-1:0] fwd, output bit haz);
    fwd = '0;
    haz = 1'b0;
    if (!used) return;
    for (int k = 0; k < DEPTH; k++) begin
      if (mq[k].v && mq[k].rd == src) begin
        if (FWD_MASK[k] && (!mq[k].ld || k >= LOAD_FWD_MIN)) fwd[k] = 1'b1;
        else haz = 1'b1;
        return;
      end
    end
  endfunction

  function automatic logic [OW-1:0] predict();
    logic [DEPTH-1:0] fr;
    logic [DEPTH-1:0] ft;
    bit hr, ht, busy, hz, nopE;
    if (rst) return '0;
    lookupModel(int'(in_rs), in_rs_used, fr, hr);
    lookupModel(int'(in_rt), in_rt_used, ft, ht);
    busy = (mCount > 0);
    hz   = in_valid && !busy && !flush && (hr || ht);
    nopE = hz || busy || flush;
    if (nopE) begin
      fr = '0;
      ft = '0;
    end
    return {hz, nopE, busy, fr, ft};
  endfunction

  function automatic void modelStep();
    logic [OW-1:0] e;
    bit issue;
    e     = predict();
    issue = in_valid && !e[OW-2];
    if (rst || flush) begin
      for (int k = 0; k < DEPTH; k++) mq[k] = '{1'b0, 0, 1'b0};
      mCount = 0;
    end else begin
      for (int k = DEPTH - 1; k > 0; k--) mq[k] = mq[k-1];
      mq[0] = '{issue && in_wr, int'(in_rd), in_load};
      if (issue && in_ctl && SQUASH_CYC > 0) mCount = SQUASH_CYC;
      else if (mCount > 0) mCount = mCount - 1;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic drive(input bit v, input int rs, input bit rsU, input int rt, input bit rtU,
                       input int rd, input bit wr, input bit ld, input bit ctl);
    in_valid   = v;
    in_rs      = REG_AW'(rs);
    in_rs_used = rsU;
    in_rt      = REG_AW'(rt);
    in_rt_used = rtU;
    in_rd      = REG_AW'(rd);
    in_wr      = wr;
    in_load    = ld;
    in_ctl     = ctl;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic drain();
    idle();
    repeat (DEPTH + SQUASH_CYC) tick();
  endtask

  task automatic test_reset();
    logic [OW-1:0] exp;
    rst   = 1'b1;
    flush = 1'b1;
    drive(1, 3, 1, 3, 1, 3, 1, 1, 1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      exp = pk(0, 0, 0, 4'b0000, 4'b0000);
      checks++;
      if (outs() !== exp) begin
        errors++;
        $display("[TB] FAIL reset_outputs: got %b want %b", outs(), exp);
      end
      tick();
    end
    rst   = 1'b0;
    flush = 1'b0;
    drive(1, 3, 1, 3, 1, 0, 0, 0, 0);
    @(negedge clk);
    exp = pk(0, 0, 0, 4'b0000, 4'b0000);
    checks++;
    if (outs() !== exp) begin
      errors++;
      $display("[TB] FAIL reset_cleared: got %b want %b", outs(), exp);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [OW-1:0] exp;
    drain();
    drive(1, 0, 0, 0, 0, 3, 1, 0, 0);
    @(negedge clk);
    exp = pk(0, 0, 0, 4'b0000, 4'b0000);
    checks++;
    if (outs() !== exp) begin
      errors++;
      $display("[TB] FAIL add_issue: got %b want %b", outs(), exp);
    end
    tick();
    drive(1, 3, 1, 5, 0, 4, 1, 0, 0);
    @(negedge clk);
    exp = pk(0, 0, 0, 4'b0001, 4'b0000);
    checks++;
    if (outs() !== exp) begin
      errors++;
      $display("[TB] FAIL sub_fwd_k0: got %b want %b", outs(), exp);
    end
    tick();
  endtask

  task automatic test_load_use();
    logic [OW-1:0] exp;
    drain();
    drive(1, 0, 0, 0, 0, 2, 1, 1, 0);
    @(negedge clk);
    exp = pk(0, 0, 0, 4'b0000, 4'b0000);
    checks++;
    if (outs() !== exp) begin
      errors++;
      $display("[TB] FAIL ld_issue: got %b want %b", outs(), exp);
    end
    tick();
    drive(1, 2, 1, 0, 0, 4, 1, 0, 0);
    @(negedge clk);
    exp = pk(1, 1, 0, 4'b0000, 4'b0000);
    checks++;
    if (outs() !== exp) begin
      errors++;
      $display("[TB] FAIL ld_use_stall: got %b want %b", outs(), exp);
    end
    tick();
    @(negedge clk);
    exp = pk(0, 0, 0, 4'b0010, 4'b0000);
    checks++;
    if (outs() !== exp) begin
      errors++;
      $display("[TB] FAIL ld_use_fwd_k1: got %b want %b", outs(), exp);
    end
    tick();
  endtask

  task automatic test_youngest();
    logic [OW-1:0] exp;
    drain();
    drive(1, 0, 0, 0, 0, 1, 1, 0, 0);
    tick();
    drive(1, 0, 0, 0, 0, 6, 1, 0, 0);
    tick();
    drive(1, 0, 0, 0, 0, 1, 1, 0, 0);
    tick();
    drive(1, 6, 1, 1, 1, 0, 0, 0, 0);
    @(negedge clk);
    exp = pk(0, 0, 0, 4'b0010, 4'b0001);
    checks++;
    if (outs() !== exp) begin
      errors++;
      $display("[TB] FAIL youngest_match: got %b want %b", outs(), exp);
    end
    tick();
  endtask

  task automatic test_nonfwd_retire();
    logic [OW-1:0] exp;
    drain();
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0);
    tick();
    idle();
    repeat (2) tick();
    drive(1, 5, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      exp = (i < 2) ? pk(1, 1, 0, 4'b0000, 4'b0000) : pk(0, 0, 0, 4'b0000, 4'b0000);
      checks++;
      if (outs() !== exp) begin
        errors++;
        $display("[TB] FAIL nonfwd_cycle%0d: got %b want %b", i, outs(), exp);
      end
      tick();
    end
  endtask

  task automatic test_squash();
    logic [OW-1:0] exp;
    drain();
    drive(1, 0, 0, 0, 0, 7, 1, 1, 0);
    tick();
    idle();
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    exp = pk(0, 0, 0, 4'b0000, 4'b0000);
    checks++;
    if (outs() !== exp) begin
      errors++;
      $display("[TB] FAIL beq_issue: got %b want %b", outs(), exp);
    end
    tick();
    drive(1, 7, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      exp = (i < 2) ? pk(0, 1, 1, 4'b0000, 4'b0000) : pk(0, 0, 0, 4'b0000, 4'b0000);
      checks++;
      if (outs() !== exp) begin
        errors++;
        $display("[TB] FAIL squash_cycle%0d: got %b want %b", i, outs(), exp);
      end
      tick();
    end
    drive(1, 0, 0, 0, 0, 2, 1, 0, 0);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    idle();
    flush = 1'b1;
    @(negedge clk);
    exp = pk(0, 1, 1, 4'b0000, 4'b0000);
    checks++;
    if (outs() !== exp) begin
      errors++;
      $display("[TB] FAIL flush_in_squash: got %b want %b", outs(), exp);
    end
    tick();
    flush = 1'b0;
    drive(1, 2, 1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    exp = pk(0, 0, 0, 4'b0000, 4'b0000);
    checks++;
    if (outs() !== exp) begin
      errors++;
      $display("[TB] FAIL after_flush: got %b want %b", outs(), exp);
    end
    tick();
  endtask

  task automatic test_flush_ctl();
    logic [OW-1:0] exp;
    drain();
    drive(1, 0, 0, 0, 0, 4, 1, 0, 0);
    tick();
    drive(1, 4, 1, 0, 0, 0, 0, 0, 1);
    flush = 1'b1;
    @(negedge clk);
    exp = pk(0, 1, 0, 4'b0000, 4'b0000);
    checks++;
    if (outs() !== exp) begin
      errors++;
      $display("[TB] FAIL flush_vs_ctl: got %b want %b", outs(), exp);
    end
    tick();
    flush = 1'b0;
    drive(1, 4, 1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    exp = pk(0, 0, 0, 4'b0000, 4'b0000);
    checks++;
    if (outs() !== exp) begin
      errors++;
      $display("[TB] FAIL flush_no_squash: got %b want %b", outs(), exp);
    end
    tick();
  endtask

  task automatic test_stalled_ctl();
    logic [OW-1:0] exp;
    logic [OW-1:0] seqExp[5];
    seqExp[0] = pk(1, 1, 0, 4'b0000, 4'b0000);
    seqExp[1] = pk(0, 0, 0, 4'b0010, 4'b0000);
    seqExp[2] = pk(0, 1, 1, 4'b0000, 4'b0000);
    seqExp[3] = pk(0, 1, 1, 4'b0000, 4'b0000);
    seqExp[4] = pk(0, 0, 0, 4'b0000, 4'b0000);
    drain();
    drive(1, 0, 0, 0, 0, 1, 1, 1, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      if (i < 2) drive(1, 1, 1, 0, 0, 0, 0, 0, 1);
      else idle();
      @(negedge clk);
      exp = seqExp[i];
      checks++;
      if (outs() !== exp) begin
        errors++;
        $display("[TB] FAIL stalled_ctl_%0d: got %b want %b", i, outs(), exp);
      end
      tick();
    end
  endtask

  task automatic test_random(input int n);
    logic [OW-1:0] exp;
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;
    for (int i = 0; i < n; i++) begin
      rst   = ($urandom_range(0, 63) == 0);
      flush = ($urandom_range(0, 15) == 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 3) != 0,
            $urandom_range(0, 7), $urandom_range(0, 1) != 0, $urandom_range(0, 7),
            $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0);
      @(negedge clk);
      exp = predict();
      checks++;
      if (outs() !== exp) begin
        errors++;
        $display("[TB] FAIL random_%0d: got %b want %b", i, outs(), exp);
      end
      tick();
    end
    rst   = 1'b0;
    flush = 1'b0;
    idle();
  endtask

  initial begin
    rst   = 1'b1;
    flush = 1'b0;
    idle();
    test_reset();
    test_back_to_back();
    test_load_use();
    test_youngest();
    test_nonfwd_retire();
    test_squash();
    test_flush_ctl();
    test_stalled_ctl();
    test_random(400);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
